// File: rtl/ddr_wr_pkg.sv
// Shared types and constants for the frame-buffer DDR write-burst controller.
//   state_e        : burst FSM states (IDLE -> AW -> DATA -> RESP)
//   BYTES_PER_BEAT : address advance per 256-bit beat
//   LEN_W          : width of a burst length counter (holds 1..256)
package ddr_wr_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_DATA, ST_RESP} state_e;

  localparam int unsigned DATA_W_DEF     = 256;
  localparam int unsigned BYTES_PER_BEAT = DATA_W_DEF / 8;
  localparam int unsigned LEN_W          = 9;
endpackage

// File: rtl/ddr_wr_skid_buf.sv
// Two-entry valid/ready buffer behind a 1-cycle-latency FIFO read port.
//   clk_i, rst_n_i : clock, synchronous active-low reset (empties buffer)
//   rd_en_i        : FIFO pop issued this cycle; data arrives next cycle
//   rd_data_i      : FIFO read data
//   room_o         : occupancy + in-flight read < 2, a new pop may be issued
//   valid_o/data_o : buffer head
//   ready_i        : consumer takes the head
module ddr_wr_skid_buf #(
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              room_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i
);
  logic [1:0][DATA_W-1:0] mem_q;
  logic                   wr_ptr_q, rd_ptr_q, infl_q;
  logic [1:0]             cnt_q;
  logic                   push, pop;

  // A read issued last cycle lands now.
  assign push    = infl_q;
  assign pop     = valid_o && ready_i;
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign room_o  = ({1'b0, cnt_q} + {2'b0, infl_q}) < 3'd2;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      infl_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      infl_q <= rd_en_i;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rd_data_i;
  end
endmodule

// File: rtl/ddr_wr_burst_ctrl.sv
// Pops 256-bit words from the pixel FIFO and issues AXI-style write bursts
// over a linear frame buffer starting at BASE_ADDR, wrapping at frame end.
//   rd_clk/rd_rst_n      : clock, synchronous active-low reset
//   enable, frame_start  : allow new bursts / restart address (latched pulse)
//   flush_req            : drain a partial burst (DDR_WR_FLUSH_EN builds only)
//   fifo_rd_*            : FIFO read side (1-cycle read latency)
//   aw*/w*/b*            : DDR write address, data and response channels
//   busy, frame_done     : not-idle flag, pulse after a frame's last B response
// Build macro: DDR_WR_FLUSH_EN enables the partial-burst flush.
module ddr_wr_burst_ctrl
  import ddr_wr_pkg::*;
#(
  parameter int unsigned       DATA_W      = 256,
  parameter int unsigned       ADDR_W      = 28,
  parameter int unsigned       RD_DEPTH_W  = 6,
  parameter int unsigned       BURST_LEN   = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       FRAME_BEATS = 129600
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic                  flush_req,
  output logic                  fifo_rd_en,
  input  logic [DATA_W-1:0]     fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic [RD_DEPTH_W:0]   fifo_rd_water_level,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  busy,
  output logic                  frame_done
);
`ifdef DDR_WR_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif
  localparam int unsigned FC_W = $clog2(FRAME_BEATS + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_nx;
  logic [FC_W-1:0]   fcnt_q, fcnt_d, fcnt_nx, rem;
  logic [LEN_W-1:0]  len_q, len_d, len_full, popc_q, popc_d, beatc_q, beatc_d;
  logic              fs_q, fs_d, fs_clr, fl_q, fl_d, fl_clr, fdone_q, fdone_d;
  logic              full_ok, pop_en, w_hs;
  logic              skid_room, skid_valid;
  logic [DATA_W-1:0] skid_data;

  // Last burst of a frame is shortened to the frame remainder.
  assign rem      = FC_W'(FRAME_BEATS) - fcnt_q;
  assign len_full = (32'(rem) >= BURST_LEN) ? LEN_W'(BURST_LEN) : LEN_W'(rem);
  assign full_ok  = 32'(fifo_rd_water_level) >= 32'(len_full);
  assign pop_en   = (popc_q < len_q) && skid_room && !fifo_rd_empty;

  assign wvalid     = (state_q == ST_DATA) && skid_valid;
  assign wdata      = wvalid ? skid_data : '0;
  assign wlast      = wvalid && (beatc_q == len_q - LEN_W'(1));
  assign w_hs       = wvalid && wready;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = fdone_q;

  ddr_wr_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk_i    (rd_clk),
    .rst_n_i  (rd_rst_n),
    .rd_en_i  (fifo_rd_en),
    .rd_data_i(fifo_rd_data),
    .room_o   (skid_room),
    .valid_o  (skid_valid),
    .data_o   (skid_data),
    .ready_i  ((state_q == ST_DATA) && wready)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    fcnt_d     = fcnt_q;
    len_d      = len_q;
    popc_d     = popc_q;
    beatc_d    = beatc_q;
    fdone_d    = 1'b0;
    fs_clr     = 1'b0;
    fl_clr     = 1'b0;
    awvalid    = 1'b0;
    awaddr     = '0;
    awlen      = '0;
    bready     = 1'b0;
    fifo_rd_en = 1'b0;
    ptr_nx     = ptr_q + ADDR_W'(len_q) * ADDR_W'(BYTES_PER_BEAT);
    fcnt_nx    = fcnt_q + FC_W'(len_q);
    unique case (state_q)
      ST_IDLE: begin
        // A pending restart takes one idle cycle so len is recomputed from 0.
        if (fs_q) begin
          ptr_d  = BASE_ADDR;
          fcnt_d = '0;
          fs_clr = 1'b1;
        end else if (enable && full_ok) begin
          len_d   = len_full;
          popc_d  = '0;
          beatc_d = '0;
          state_d = ST_AW;
        end else if (FLUSH_EN && fl_q) begin
          if (fifo_rd_water_level == '0) begin
            fl_clr = 1'b1;
          end else if (enable) begin
            len_d   = LEN_W'(fifo_rd_water_level);
            popc_d  = '0;
            beatc_d = '0;
            fl_clr  = 1'b1;
            state_d = ST_AW;
          end
        end
      end
      ST_AW: begin
        awvalid    = 1'b1;
        awaddr     = ptr_q;
        awlen      = 8'(len_q - LEN_W'(1));
        fifo_rd_en = pop_en;
        if (awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        fifo_rd_en = pop_en;
        if (w_hs && wlast) state_d = ST_RESP;
      end
      ST_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          state_d = ST_IDLE;
          if (fcnt_nx == FC_W'(FRAME_BEATS)) begin
            ptr_d   = BASE_ADDR;
            fcnt_d  = '0;
            fdone_d = 1'b1;
          end else begin
            ptr_d  = ptr_nx;
            fcnt_d = fcnt_nx;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fifo_rd_en) popc_d  = popc_q + LEN_W'(1);
    if (w_hs)       beatc_d = beatc_q + LEN_W'(1);
    fs_d = frame_start || (fs_q && !fs_clr);
    fl_d = FLUSH_EN && (flush_req || (fl_q && !fl_clr));
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE_ADDR;
      fcnt_q  <= '0;
      len_q   <= '0;
      popc_q  <= '0;
      beatc_q <= '0;
      fs_q    <= 1'b0;
      fl_q    <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fcnt_q  <= fcnt_d;
      len_q   <= len_d;
      popc_q  <= popc_d;
      beatc_q <= beatc_d;
      fs_q    <= fs_d;
      fl_q    <= fl_d;
      fdone_q <= fdone_d;
    end
  end
endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Bench for ddr_wr_burst_ctrl: FIFO and DDR-slave models plus a frame-level
// reference model of burst addresses, lengths, data order and frame_done.
module tb_ddr_wr_burst_ctrl;
  localparam int FRAME = 40;
  localparam int BURST = 16;
`ifdef DDR_WR_FLUSH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic         rd_clk = 1'b0;
  logic         rd_rst_n, enable, frame_start, flush_req;
  logic         fifo_rd_en, fifo_rd_empty;
  logic [255:0] fifo_rd_data, wdata;
  logic [6:0]   fifo_rd_water_level;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready, busy, frame_done;
  logic [27:0]  awaddr;
  logic [7:0]   awlen;

  ddr_wr_burst_ctrl #(.DATA_W(256), .ADDR_W(28), .RD_DEPTH_W(6), .BURST_LEN(BURST),
                      .BASE_ADDR(28'h0), .FRAME_BEATS(FRAME)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable), .frame_start(frame_start),
    .flush_req(flush_req), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .busy(busy), .frame_done(frame_done));

  always #5 rd_clk = ~rd_clk;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // FIFO contents and reference-model state
  logic [255:0] fifo_q[$], popped[$];
  int           aw_addr_log[$], aw_len_log[$], beat_log[$];
  logic [27:0]  mptr;
  int           mfcnt, cur_len, beats, pops_b, b_dly, bursts_done, fd_seen, pre_occ, elen;
  bit           fs_pend, fl_pend, fd_pend, wr_toggle;
  logic         nx_bvalid, nx_wready;
  logic [255:0] nx_rdata, exp_w;
  int           seq = 0;

  // Agent: observes handshakes at negedge (they complete at the next posedge),
  // updates the model, then drives FIFO/DDR-side inputs just after posedge.
  initial begin
    fifo_rd_data = '0; fifo_rd_empty = 1'b1; fifo_rd_water_level = '0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    mptr = '0; mfcnt = 0; cur_len = 0; beats = 0; pops_b = 0; b_dly = 0;
    bursts_done = 0; fd_seen = 0; fs_pend = 0; fl_pend = 0; fd_pend = 0; wr_toggle = 0;
    forever begin
      @(negedge rd_clk);
      pre_occ   = popped.size();
      nx_bvalid = bvalid;
      nx_rdata  = fifo_rd_data;
      if (!rd_rst_n) begin
        if (fifo_rd_en && fifo_q.size() > 0) nx_rdata = fifo_q.pop_front();
        popped.delete();
        fs_pend = 0; fl_pend = 0; fd_pend = 0; b_dly = 0; nx_bvalid = 1'b0;
        mptr = '0; mfcnt = 0;
      end else begin
        if (fd_pend || frame_done) begin
          chk("frame_done", frame_done, fd_pend);
          if (frame_done) fd_seen++;
        end
        fd_pend = 0;
        if (frame_start) fs_pend = 1;
        if (FL && flush_req) fl_pend = 1;
        if (awvalid && awready) begin
          if (fs_pend) begin mptr = '0; mfcnt = 0; fs_pend = 0; end
          elen = (FRAME - mfcnt < BURST) ? FRAME - mfcnt : BURST;
          if (FL && fl_pend && fifo_q.size() < elen) begin elen = fifo_q.size(); fl_pend = 0; end
          chk("awaddr", awaddr, mptr);
          chk("awlen", awlen, elen - 1);
          aw_addr_log.push_back(int'(awaddr));
          aw_len_log.push_back(int'(awlen));
          cur_len = elen; beats = 0; pops_b = 0;
        end
        if (fifo_rd_en) begin
          chk("rd_room", pre_occ < 2, 1'b1);
          chk("rd_within_len", pops_b < cur_len, 1'b1);
          chk("rd_not_empty", fifo_q.size() > 0, 1'b1);
          if (fifo_q.size() > 0) begin
            nx_rdata = fifo_q.pop_front();
            popped.push_back(nx_rdata);
          end
          pops_b++;
        end
        if (wvalid && wready) begin
          if (popped.size() == 0) chk("w_without_pop", 1'b1, 1'b0);
          else begin
            exp_w = popped.pop_front();
            chk("wdata", wdata, exp_w);
          end
          chk("wlast", wlast, beats == cur_len - 1);
          beats++;
          if (wlast) begin
            chk("pops_per_burst", pops_b, cur_len);
            beat_log.push_back(beats);
            b_dly = 2;
          end
        end
        if (bvalid && bready) begin
          mptr  = mptr + 28'(cur_len * 32);
          mfcnt = mfcnt + cur_len;
          if (mfcnt == FRAME) begin mptr = '0; mfcnt = 0; fd_pend = 1; end
          nx_bvalid = 1'b0;
          bursts_done++;
        end else if (b_dly > 0) begin
          b_dly--;
          if (b_dly == 0) nx_bvalid = 1'b1;
        end
      end
      nx_wready = wr_toggle ? ~wready : 1'b1;
      @(posedge rd_clk); #1;
      fifo_rd_data        = nx_rdata;
      fifo_rd_empty       = (fifo_q.size() == 0);
      fifo_rd_water_level = 7'(fifo_q.size());
      bvalid              = nx_bvalid;
      wready              = nx_wready;
    end
  end

  task automatic tick(); @(posedge rd_clk); #2; endtask
  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin fifo_q.push_back({8{32'h5000_0000 + 32'(seq)}}); seq++; end
  endtask
  task automatic wait_bursts(input int n);
    int t = 0;
    while (bursts_done < n && t < 400) begin tick(); t++; end
    chk("burst_wait", bursts_done >= n, 1'b1);
  endtask
  task automatic wait_aw(input int n);
    int t = 0;
    while (aw_addr_log.size() < n && t < 400) begin tick(); t++; end
    chk("aw_wait", aw_addr_log.size() >= n, 1'b1);
  endtask
  task automatic chk_aw(input int idx, input int addr, input int len);
    if (idx < aw_addr_log.size()) begin
      chk("lit_awaddr", aw_addr_log[idx], addr);
      chk("lit_awlen", aw_len_log[idx], len);
    end else chk("lit_aw_present", 1'b0, 1'b1);
  endtask

  int naw, r;
  initial begin
    rd_rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; flush_req = 1'b0;
    repeat (3) tick();
    chk("rst_ctl", {awvalid, wvalid, wlast, bready, busy, frame_done, fifo_rd_en}, 7'b0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0);
    chk("rst_wdata", wdata, 0);
    rd_rst_n = 1'b1; enable = 1'b1;

    // 1: level 15 holds off, 16 starts a full burst
    push(15);
    repeat (20) tick();
    chk("no_aw_at_15", aw_addr_log.size(), 0);
    chk("idle_at_15", busy, 1'b0);
    push(1);
    wait_bursts(1);
    chk_aw(0, 'h0, 15);
    chk("lit_beats0", beat_log[0], 16);

    // 2: wready toggling every cycle
    wr_toggle = 1;
    push(16);
    wait_bursts(2);
    wr_toggle = 0;
    chk_aw(1, 'h200, 15);
    chk("lit_beats1", beat_log[1], 16);

    // 3: frame remainder burst, frame_done, address wrap
    push(8);
    wait_bursts(3);
    repeat (3) tick();
    chk_aw(2, 'h400, 7);
    chk("lit_frame_done", fd_seen, 1);
    push(16);
    wait_bursts(4);
    chk_aw(3, 'h0, 15);

    // 4: frame_start mid-DATA of the burst at 0x200
    push(16);
    wait_aw(5);
    repeat (2) tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_bursts(5);
    push(16);
    wait_bursts(6);
    chk_aw(4, 'h200, 15);
    chk_aw(5, 'h0, 15);

    // 5: reset mid-DATA, next burst from BASE_ADDR
    push(16);
    wait_aw(7);
    repeat (3) tick();
    rd_rst_n = 1'b0; tick();
    chk("midrst_ctl", {awvalid, wvalid, wlast, bready, busy, frame_done, fifo_rd_en}, 7'b0);
    chk("midrst_wdata", wdata, 0);
    rd_rst_n = 1'b1;
    push(16);
    wait_bursts(7);
    chk_aw(7, 'h0, 15);

    // 6: leave exactly 5 words behind, then flush
    repeat (10) tick();
    r = fifo_q.size();
    push((5 - r + 32) % 16);
    repeat (80) tick();
    chk("pre_flush_level", fifo_q.size(), 5);
    naw = aw_addr_log.size();
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    repeat (60) tick();
    if (FL) begin
      chk("flush_aw_count", aw_addr_log.size(), naw + 1);
      if (aw_len_log.size() > naw) chk("lit_flush_awlen", aw_len_log[naw], 4);
      if (beat_log.size() > 0) chk("lit_flush_beats", beat_log[beat_log.size()-1], 5);
    end else begin
      chk("no_flush_aw", aw_addr_log.size(), naw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ddr_wr_burst_ctrl.md
Name: ddr_wr_burst_ctrl

Overview:
- Downstream consumer of the 16-bit-in / 256-bit-out pixel FIFO in the video frame-buffer write path.
- Monitors the FIFO read-side water level. Once a full burst is buffered, it pops 256-bit words and issues AXI-style write bursts (AW/W/B channels) to the DDR controller.
- Walks a linear frame buffer from BASE_ADDR and wraps at frame end.

Parameters:
- DATA_W, 256, write data width (bits); must equal the FIFO read width.
- ADDR_W, 28, byte address width.
- RD_DEPTH_W, 6, FIFO read depth width; water level is RD_DEPTH_W+1 bits.
- BURST_LEN, 16, beats per full burst (1..256).
- BASE_ADDR, 0, frame buffer start byte address.
- FRAME_BEATS, 129600, 256-bit beats per frame (1920x1080x16bpp / 256).

Ports:
- rd_clk  in  1  clock (same clock as the FIFO read side).
- rd_rst_n  in  1  synchronous active-low reset.
- enable  in  1  allow new bursts to start.
- frame_start  in  1  single-cycle pulse; restart the address at BASE_ADDR.
- flush_req  in  1  single-cycle pulse; drain a partial burst (optional feature only).
- fifo_rd_en  out  1  FIFO pop.
- fifo_rd_data  in  DATA_W  FIFO data, valid 1 cycle after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rd_water_level  in  RD_DEPTH_W+1  FIFO occupancy in words.
- awvalid  out  1 / awready  in  1  address handshake.
- awaddr  out  ADDR_W  burst byte address.
- awlen  out  8  beats minus 1.
- wvalid  out  1 / wready  in  1  data handshake.
- wdata  out  DATA_W  data beat.
- wlast  out  1  last beat of the burst.
- bvalid  in  1 / bready  out  1  response handshake.
- busy  out  1  asserted whenever state is not IDLE.
- frame_done  out  1  1-cycle pulse after the B response of a frame's final burst.

Behaviour:
Reset:
- rd_rst_n=0 sampled on a rd_clk edge: state=IDLE, address pointer=BASE_ADDR, frame beat count=0.
- Skid buffer emptied; pending frame_start and flush flags cleared.
- All outputs 0.
- Reset mid-burst abandons the burst without completing the handshake; the DDR side is reset together with this block.

FSM: IDLE -> AW -> DATA -> RESP -> IDLE.
- IDLE: compute len = min(BURST_LEN, FRAME_BEATS - frame_cnt).
  - Go to AW when enable=1 and fifo_rd_water_level >= len.
  - A pending frame_start is applied here first: pointer=BASE_ADDR, frame_cnt=0, flag cleared.
- AW: awvalid=1 with awaddr and awlen=len-1 held stable; go to DATA on awready.
  - FIFO prefetch of up to 2 words may begin in AW.
- DATA: exits to RESP when the beat with wlast=1 is accepted.
- RESP: bready=1; on bvalid go to IDLE.
  - pointer += len*DATA_W/8; frame_cnt += len.
  - If frame_cnt reaches FRAME_BEATS: pointer=BASE_ADDR, frame_cnt=0, pulse frame_done.

FIFO read path:
- 1-cycle read latency; popped data lands in a 2-entry skid buffer.
- fifo_rd_en=1 only when all hold:
  - popped count < len;
  - skid occupancy + in-flight reads < 2;
  - fifo_rd_empty=0.
- wvalid = skid non-empty; wdata = skid head.
- Beat accepted when wvalid & wready; then beat count increments.
- wlast=1 exactly on beat len-1.
- wready stalls of any length lose no data and never over-pop the FIFO.

Events and boundaries:
- frame_start during AW/DATA/RESP is latched; the current burst completes at its old address.
- enable=0 mid-burst: the burst completes; no new AW until enable=1.
- Final burst of a frame is short (FRAME_BEATS mod BURST_LEN beats) when the remainder is non-zero.
- Only one outstanding burst at a time.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
Macro DDR_WR_FLUSH_EN.
- Defined: a flush_req pulse is latched.
  - In IDLE with fifo_rd_water_level in 1..len-1, issue a burst of len = water level, then clear the flag.
  - With level 0, clear the flag and issue nothing.
- Undefined: flush_req is ignored; only full-length bursts, or the frame-remainder burst, are issued.

Decomposition:
- Package ddr_wr_pkg:
  - FSM state enum (IDLE, AW, DATA, RESP);
  - BYTES_PER_BEAT = DATA_W/8;
  - burst-length width constant.
- One sub-module: ddr_wr_skid_buf, the 2-entry valid/ready buffer with an in-flight counter.

Test Plan:
1. Water level 15 -> no AW. Level rises to 16 -> awaddr=0x0, awlen=15, 16 pops, 16 beats, wlast on beat 16.
2. wready toggling 1/0 every cycle over a 16-beat burst -> data order intact, exactly 16 pops, fifo_rd_en never asserted with skid full.
3. Two back-to-back bursts -> second awaddr=0x200. FRAME_BEATS=40 -> third burst awlen=7, then frame_done pulse and next awaddr=0x0.
4. frame_start pulsed mid-DATA of the burst at 0x200 -> burst finishes; next awaddr=0x0.
5. rd_rst_n=0 mid-DATA for 1 cycle -> all outputs 0, state IDLE; the next burst starts at BASE_ADDR.
6. DDR_WR_FLUSH_EN defined, level=5, flush_req pulse -> awlen=4, 5 beats. Without the macro -> no AW issued.
